// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode VGA timing generator. Counters walk the frame,
// a request stage asks the pixel source for (x,y) REQ_LEAD cycles ahead, and
// a flag pipeline of matching depth realigns HS/VS/DE with the returned pixel.
module vga_timing_gen #(
  parameter int              CW       = 11,
  parameter int              PIX_W    = 16,
  parameter int              REQ_LEAD = 2,
  parameter bit              HS_POL   = 1'b1,
  parameter bit              VS_POL   = 1'b1,
  parameter logic [4*CW-1:0] M0_H     = {CW'(96),  CW'(48),  CW'(640),  CW'(800)},
  parameter logic [4*CW-1:0] M0_V     = {CW'(2),   CW'(33),  CW'(480),  CW'(525)},
  parameter logic [4*CW-1:0] M1_H     = {CW'(136), CW'(160), CW'(1024), CW'(1344)},
  parameter logic [4*CW-1:0] M1_V     = {CW'(6),   CW'(29),  CW'(768),  CW'(806)}
) (
  input  logic             vga_clk,
  input  logic             sys_rst_n,
  input  logic             vga_mode,
  output logic             pix_req,
  output logic [CW-1:0]    pix_x,
  output logic [CW-1:0]    pix_y,
  input  logic [PIX_W-1:0] pix_data,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             vga_de,
  output logic [PIX_W-1:0] vga_rgb,
  output logic             frame_start,
  output logic             line_end,
  output logic             mode_active
);

  typedef struct packed {
    logic [CW-1:0] sync;
    logic [CW-1:0] back;
    logic [CW-1:0] disp;
    logic [CW-1:0] total;
  } tim_t;

  // Per-position flags that travel alongside the outstanding pixel fetch
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic lend;
    logic fs;
  } flg_t;

  logic [CW-1:0]      cnt_h_q, cnt_h_d, cnt_v_q, cnt_v_d;
  logic               mode_q, mode_d;
  tim_t               th, tv;
  logic [CW-1:0]      h_lo, h_hi, v_lo, v_hi;
  logic               h_last, v_last, h_act, v_act, act;
  logic               req_q, req_d;
  logic [CW-1:0]      px_q, px_d, py_q, py_d;
  flg_t [REQ_LEAD:0]  pipe_q, pipe_d;
  logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, le_q, le_d;
  logic [PIX_W-1:0]   rgb_q, rgb_d;

  // Timing set follows the mode latched at the last frame wrap; decode position
  always_comb begin
    th     = mode_q ? tim_t'(M1_H) : tim_t'(M0_H);
    tv     = mode_q ? tim_t'(M1_V) : tim_t'(M0_V);
    h_lo   = th.sync + th.back;
    h_hi   = h_lo + th.disp;
    v_lo   = tv.sync + tv.back;
    v_hi   = v_lo + tv.disp;
    h_last = (cnt_h_q == th.total - CW'(1));
    v_last = (cnt_v_q == tv.total - CW'(1));
    h_act  = (cnt_h_q >= h_lo) && (cnt_h_q < h_hi);
    v_act  = (cnt_v_q >= v_lo) && (cnt_v_q < v_hi);
    act    = h_act && v_act;
  end

  // Counter advance; vga_mode is only looked at on the frame-wrap cycle
  always_comb begin
    cnt_h_d = cnt_h_q + CW'(1);
    cnt_v_d = cnt_v_q;
    mode_d  = mode_q;
    if (h_last) begin
      cnt_h_d = '0;
      if (v_last) begin
        cnt_v_d = '0;
        mode_d  = vga_mode;
      end else begin
        cnt_v_d = cnt_v_q + CW'(1);
      end
    end
  end

  // Request stage and flag pipeline input; coordinates are zero off-screen
  always_comb begin
    req_d        = act;
    px_d         = act ? cnt_h_q - h_lo : '0;
    py_d         = act ? cnt_v_q - v_lo : '0;
    pipe_d[0].hs   = (cnt_h_q < th.sync);
    pipe_d[0].vs   = (cnt_v_q < tv.sync);
    pipe_d[0].act  = act;
    // first blank position after the last active pixel of an active line
    pipe_d[0].lend = v_act && (cnt_h_q == h_hi);
    pipe_d[0].fs   = (cnt_h_q == '0) && (cnt_v_q == '0);
    for (int i = 1; i <= REQ_LEAD; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Output stage: flags leave the pipe together with the fetched pixel
  always_comb begin
    hs_d  = pipe_q[REQ_LEAD].hs ~^ HS_POL;
    vs_d  = pipe_q[REQ_LEAD].vs ~^ VS_POL;
    de_d  = pipe_q[REQ_LEAD].act;
    rgb_d = pipe_q[REQ_LEAD].act ? pix_data : '0;
    fs_d  = pipe_q[REQ_LEAD].fs;
    le_d  = pipe_q[REQ_LEAD].lend;
  end

  // All state, async clear so the pins go idle without a clock
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      mode_q  <= 1'b0;
      req_q   <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      pipe_q  <= '0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      mode_q  <= mode_d;
      req_q   <= req_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pipe_q  <= pipe_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      le_q    <= le_d;
    end
  end

  assign pix_req     = req_q;
  assign pix_x       = px_q;
  assign pix_y       = py_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_de      = de_q;
  assign vga_rgb     = rgb_q;
  assign frame_start = fs_q;
  assign line_end    = le_q;
  assign mode_active = mode_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with shrunken modes so whole frames fit in a short
// run. A frame-position model (cycle index -> mode/h/v by div/mod) predicts
// every output each cycle; a table of per-frame statistics and a few
// hand-written sequences cover first fetch, mode switching and async reset.
module tb_vga_timing_gen;
  localparam int CW = 11;
  localparam int PW = 16;
  localparam int L  = 2;
  localparam bit HSP = 1'b1;
  localparam bit VSP = 1'b0;
  localparam logic [4*CW-1:0] TM0H = {11'd4, 11'd3, 11'd8,  11'd20};
  localparam logic [4*CW-1:0] TM0V = {11'd2, 11'd2, 11'd5,  11'd12};
  localparam logic [4*CW-1:0] TM1H = {11'd3, 11'd2, 11'd10, 11'd18};
  localparam logic [4*CW-1:0] TM1V = {11'd1, 11'd3, 11'd6,  11'd13};

  // {sync, back, disp, total} per mode for the model
  int mh [2][4] = '{'{4, 3, 8, 20}, '{3, 2, 10, 18}};
  int mv [2][4] = '{'{2, 2, 5, 12}, '{1, 3, 6, 13}};

  logic          vga_clk, sys_rst_n, vga_mode;
  logic          pix_req;
  logic [CW-1:0] pix_x, pix_y;
  logic [PW-1:0] pix_data;
  logic          vga_hs, vga_vs, vga_de;
  logic [PW-1:0] vga_rgb;
  logic          frame_start, line_end, mode_active;

  vga_timing_gen #(
    .CW(CW), .PIX_W(PW), .REQ_LEAD(L), .HS_POL(HSP), .VS_POL(VSP),
    .M0_H(TM0H), .M0_V(TM0V), .M1_H(TM1H), .M1_V(TM1V)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .vga_mode(vga_mode),
    .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .frame_start(frame_start), .line_end(line_end), .mode_active(mode_active)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  typedef struct { int m; int h; int v; } pos_t;
  typedef struct packed {
    logic req; logic [10:0] x; logic [10:0] y;
    logic hs; logic vs; logic de; logic [15:0] rgb;
    logic fs; logic le; logic ma;
  } obs_t;
  typedef struct {
    bit mode; int period; int hs; int vs; int de; int le; logic [15:0] last_rgb;
  } vec_t;

  pos_t          pq[$];
  int            cyc, fr_base, cur_mode, ma_hits;
  int            tests, fails;
  logic [PW-1:0] hist [0:L];

  function automatic void dec(input pos_t p, output bit hs, output bit vs, output bit act,
                              output bit le, output bit fs, output int x, output int y);
    int hb, vb;
    bit va;
    hb  = mh[p.m][0] + mh[p.m][1];
    vb  = mv[p.m][0] + mv[p.m][1];
    hs  = p.h < mh[p.m][0];
    vs  = p.v < mv[p.m][0];
    va  = (p.v >= vb) && (p.v < vb + mv[p.m][2]);
    act = va && (p.h >= hb) && (p.h < hb + mh[p.m][2]);
    le  = va && (p.h == hb + mh[p.m][2]);
    fs  = (p.h == 0) && (p.v == 0);
    x   = act ? p.h - hb : 0;
    y   = act ? p.v - vb : 0;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o = '0;
    o.hs = ~HSP;
    o.vs = ~VSP;
    return o;
  endfunction

  function automatic obs_t model_obs(int n);
    obs_t o;
    bit hs, vs, act, le, fs;
    int x, y;
    o = reset_obs();
    if (n >= 1) begin
      dec(pq[n-1], hs, vs, act, le, fs, x, y);
      o.req = act; o.x = 11'(x); o.y = 11'(y);
    end
    if (n >= L + 2) begin
      dec(pq[n-L-2], hs, vs, act, le, fs, x, y);
      o.hs  = hs ? HSP : ~HSP;
      o.vs  = vs ? VSP : ~VSP;
      o.de  = act;
      o.rgb = act ? {8'(y), 8'(x)} : 16'h0;
      o.fs  = fs;
      o.le  = le;
    end
    o.ma = (pq[n].m == 1);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.req = pix_req; o.x = pix_x; o.y = pix_y;
    o.hs = vga_hs; o.vs = vga_vs; o.de = vga_de; o.rgb = vga_rgb;
    o.fs = frame_start; o.le = line_end; o.ma = mode_active;
    return o;
  endfunction

  task automatic cmp_int(input string nm, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Counter position for cycle cyc; a new frame picks up vga_mode as it
  // stood at the wrap edge (inputs are only changed after the model step)
  task automatic model_step();
    pos_t p;
    int per;
    if (cyc > 0) begin
      p   = pq[cyc-1];
      per = mh[p.m][3] * mv[p.m][3];
      if (cyc - 1 - fr_base == per - 1) begin
        fr_base  = cyc;
        cur_mode = int'(vga_mode);
      end
    end
    p.m = cur_mode;
    p.h = (cyc - fr_base) % mh[cur_mode][3];
    p.v = (cyc - fr_base) / mh[cur_mode][3];
    pq.push_back(p);
  endtask

  task automatic check_cycle();
    obs_t e, g;
    e = model_obs(cyc);
    g = dut_obs();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL pipe cyc=%0d: got %h want %h", cyc, g, e);
    end
  endtask

  // Pixel source: answers each request L cycles later, garbage otherwise
  task automatic drive_src();
    for (int i = L; i > 0; i--) hist[i] = hist[i-1];
    hist[0]  = pix_req ? {pix_y[7:0], pix_x[7:0]} : 16'($urandom);
    pix_data = hist[L];
  endtask

  task automatic tick();
    @(negedge vga_clk);
    cyc++;
    model_step();
    check_cycle();
    drive_src();
    if (mode_active === 1'b1) ma_hits++;
  endtask

  task automatic release_rst();
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    cyc = 0; fr_base = 0; cur_mode = 0;
    pq.delete();
    for (int i = 0; i <= L; i++) hist[i] = '0;
    model_step();
    check_cycle();
    drive_src();
  endtask

  task automatic check_reset(input string nm);
    obs_t e, g;
    e = reset_obs();
    g = dut_obs();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
  endtask

  // Gather per-frame statistics from one frame_start to the next
  task automatic measure(input vec_t e);
    int g, n, hs, vs, de, le, la;
    logic [15:0] last;
    logic prev_de;
    g = 0;
    while (frame_start !== 1'b1 && g < 3000) begin tick(); g++; end
    n = 0; hs = 0; vs = 0; de = 0; le = 0; la = 0; last = 16'hxxxx; prev_de = 1'b0;
    do begin
      if (vga_hs === HSP) hs++;
      if (vga_vs === VSP) vs++;
      if (vga_de === 1'b1) begin de++; last = vga_rgb; end
      if (line_end === 1'b1) le++;
      if (line_end === 1'b1 && prev_de && vga_de === 1'b0) la++;
      prev_de = vga_de;
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 3000);
    cmp_int("frame_period", n, e.period);
    cmp_int("hs_active", hs, e.hs);
    cmp_int("vs_active", vs, e.vs);
    cmp_int("de_count", de, e.de);
    cmp_int("line_end_count", le, e.le);
    cmp_int("line_end_after_de", la, e.le);
    cmp_int("last_rgb", int'(last), int'(e.last_rgb));
  endtask

  vec_t tbl [2];

  initial begin
    int g, k;
    tbl[0] = '{mode: 1'b0, period: 240, hs: 48, vs: 40, de: 40, le: 5, last_rgb: 16'h0407};
    tbl[1] = '{mode: 1'b1, period: 234, hs: 39, vs: 18, de: 60, le: 6, last_rgb: 16'h0509};
    tests = 0; fails = 0; ma_hits = 0;
    cyc = 0; fr_base = 0; cur_mode = 0;
    sys_rst_n = 1'b0; vga_mode = 1'b0; pix_data = '0;
    repeat (3) @(negedge vga_clk);
    check_reset("reset_state");
    release_rst();

    // first fetch and first displayed pixel
    g = 0;
    while (pix_req !== 1'b1 && g < 1000) begin tick(); g++; end
    cmp_int("first_req_cyc", cyc, 88);
    while (cyc < 90) tick();
    cmp_int("de_before_first", int'(vga_de), 0);
    tick();
    cmp_int("first_de", int'(vga_de), 1);
    cmp_int("first_rgb", int'(vga_rgb), 0);

    // per-mode frame statistics
    for (int i = 0; i < 2; i++) begin
      vga_mode = tbl[i].mode;
      g = 0;
      while (mode_active !== tbl[i].mode && g < 2000) begin tick(); g++; end
      cmp_int("mode_reached", int'(mode_active), int'(tbl[i].mode));
      measure(tbl[i]);
    end

    // back to mode 0, then a mid-frame pulse that must be ignored
    vga_mode = 1'b0;
    g = 0;
    while (mode_active !== 1'b0 && g < 2000) begin tick(); g++; end
    cmp_int("back_to_mode0", int'(mode_active), 0);
    ma_hits = 0;
    while (cyc - fr_base < 60) tick();
    vga_mode = 1'b1;
    while (cyc - fr_base < 120) tick();
    vga_mode = 1'b0;
    measure(tbl[0]);
    cmp_int("pulse_ignored", ma_hits, 0);

    // raise mid-frame: takes effect exactly at the wrap
    g = 0;
    while (cyc - fr_base != 120 && g < 1000) begin tick(); g++; end
    vga_mode = 1'b1;
    k = cyc;
    g = 0;
    while (mode_active !== 1'b1 && g < 1000) begin tick(); g++; end
    cmp_int("switch_delay", cyc - k, 120);
    measure(tbl[1]);

    // async reset in the middle of a mode-1 frame
    g = 0;
    while (!(cur_mode == 1 && cyc - fr_base == 131) && g < 1000) begin tick(); g++; end
    cmp_int("pre_reset_mode", int'(mode_active), 1);
    #2 sys_rst_n = 1'b0;
    #1 check_reset("async_reset");
    repeat (2) @(negedge vga_clk);
    release_rst();
    measure(tbl[0]);

    // randomized mode requests, checked cycle by cycle against the model
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 299) == 0) vga_mode = ~vga_mode;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
